// File: rtl/data_mem_master_pkg.sv
// Shared encodings for the MEM-stage data-memory initiator: access sizes,
// FSM states and byte-lane masks.
package data_mem_master_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_e;

  // Size code 2'b11 behaves as a word access.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_master_lane_align.sv
// Little-endian lane placement for stores and lane extraction plus
// sign/zero extension for loads over a two-word window.
module mem_lane_align
  import data_mem_master_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] sdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  mask_o,
  output logic [63:0] wdata_o,
  output logic [31:0] load_o
);

  logic [3:0]  bmask;
  logic [31:0] sh;

  always_comb begin
    case (size_i)
      SZ_BYTE: bmask = MASK_BYTE;
      SZ_HALF: bmask = MASK_HALF;
      SZ_WORD: bmask = MASK_WORD;
      default: bmask = MASK_WORD;
    endcase
  end

  assign mask_o  = {4'b0000, bmask} << offset_i;
  assign wdata_o = {32'h0000_0000, sdata_i} << {offset_i, 3'b000};
  assign sh      = 32'(rdata_i >> {offset_i, 3'b000});

  always_comb begin
    case (size_i)
      SZ_BYTE: load_o = unsigned_i ? {24'h00_0000, sh[7:0]}
                                   : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: load_o = unsigned_i ? {16'h0000, sh[15:0]}
                                   : {{16{sh[15]}}, sh[15:0]};
      SZ_WORD: load_o = sh;
      default: load_o = sh;
    endcase
  end

endmodule

// File: rtl/data_mem_master.sv
// MEM-stage initiator: turns a byte-addressed load/store into one or two
// word transactions over a req/ack handshake and stalls the pipeline meanwhile.
module data_mem_master
  import data_mem_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic              MemWrite_i,
  input  logic              MemRead_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [31:0]       data_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rlo_q, rlo_d;
  logic [31:0]       rhi_q, rhi_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d;
  logic              split_q, split_d;
  logic              gap_q, gap_d;

  logic [7:0]        lane_mask;
  logic [63:0]       lane_wdata;
  logic [31:0]       lane_load;
  logic [ADDR_W-1:0] word_addr;
  logic              req_any;
  logic              split_in;

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign req_any   = MemRead_i | MemWrite_i;
  assign split_in  = ({1'b0, addr_i[1:0]} + size_nbytes(size_i)) > 3'd4;

  mem_lane_align u_align (
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .sdata_i    (data_q),
    .rdata_i    ({rhi_q, rlo_q}),
    .mask_o     (lane_mask),
    .wdata_o    (lane_wdata),
    .load_o     (lane_load)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rlo_q   <= '0;
      rhi_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      split_q <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rlo_q   <= rlo_d;
      rhi_q   <= rhi_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      split_q <= split_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rlo_d       = rlo_q;
    rhi_d       = rhi_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    rd_d        = rd_q;
    split_d     = split_q;
    gap_d       = gap_q;
    data_o      = '0;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        // Stall is combinational on the request; keep it low while in reset.
        stall_o = req_any & rst_i;
        if (req_any) begin
          addr_d  = addr_i;
          data_d  = data_i;
          size_d  = size_i;
          uns_d   = unsigned_i;
          we_d    = MemWrite_i;
          rd_d    = MemRead_i & ~MemWrite_i;
          split_d = split_in;
          gap_d   = 1'b0;
          state_d = ACC0;
        end
      end
      ACC0: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = word_addr;
        mem_be_o    = lane_mask[3:0];
        mem_wdata_o = lane_wdata[31:0];
        if (mem_ack_i) begin
          rlo_d   = mem_rdata_i;
          gap_d   = split_q;
          state_d = split_q ? ACC1 : DONE;
        end
      end
      ACC1: begin
        // First ACC1 cycle (gap_q) is the mandatory req-low gap between words.
        stall_o     = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = word_addr + ADDR_W'(4);
        mem_be_o    = lane_mask[7:4];
        mem_wdata_o = lane_wdata[63:32];
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          mem_req_o = 1'b1;
          if (mem_ack_i) begin
            rhi_d   = mem_rdata_i;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        data_o  = rd_q ? lane_load : '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_master.sv
// Scoreboard bench for data_mem_master: expected memory transactions and
// load results are queued at stimulus time and checked as the DUT produces them.
module tb_data_mem_master;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [1:0]  size = '0;
  logic        uns = 1'b0;
  logic [31:0] data_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata = 32'hBAD0_BAD0;
  logic        mem_ack = 1'b0;

  txn_t        exp_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] mem [int unsigned];

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  data_mem_master #(.ADDR_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .addr_i      (addr),
    .data_i      (wdata),
    .MemWrite_i  (mem_write),
    .MemRead_i   (mem_read),
    .size_i      (size),
    .unsigned_i  (uns),
    .data_o      (data_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned k = a;
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w = mem_rd(a);
    int unsigned k = a;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    mem[k] = w;
  endtask

  task automatic push_txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] d);
    txn_t t;
    t.addr = a; t.we = we; t.be = be; t.wdata = d;
    exp_q.push_back(t);
  endtask

  // Drives one request and plays the memory side until the DONE cycle.
  task automatic run_access(input logic [31:0] a, input logic [31:0] d, input logic wr,
                            input logic rd, input logic [1:0] sz, input logic un,
                            input int unsigned delay,
                            output int unsigned cycles, output int unsigned stalls);
    txn_t        cur;
    logic        in_txn = 1'b0;
    logic        done = 1'b0;
    int unsigned waitc = 0;
    logic [31:0] h_addr, h_wdata, exp_d;
    logic [3:0]  h_be;
    logic        h_we;
    @(posedge clk); #1;
    addr = a; wdata = d; mem_write = wr; mem_read = rd; size = sz; uns = un;
    cycles = 0; stalls = 0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (stall_o) stalls++;
      mem_ack = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      if (mem_req_o) begin
        if (!in_txn) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_txn addr=%h we=%b be=%b wdata=%h",
                     mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
          end else begin
            cur = exp_q.pop_front();
            if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !==
                {cur.addr, cur.we, cur.be, cur.wdata}) begin
              n_fail++;
              $display("FAIL txn got addr=%h we=%b be=%b wdata=%h want addr=%h we=%b be=%b wdata=%h",
                       mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
                       cur.addr, cur.we, cur.be, cur.wdata);
            end
          end
          h_addr = mem_addr_o; h_we = mem_we_o; h_be = mem_be_o; h_wdata = mem_wdata_o;
          in_txn = 1'b1;
          waitc = 0;
        end else begin
          n_checks++;
          if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {h_addr, h_we, h_be, h_wdata}) begin
            n_fail++;
            $display("FAIL hold_stable got addr=%h be=%b wdata=%h want addr=%h be=%b wdata=%h",
                     mem_addr_o, mem_be_o, mem_wdata_o, h_addr, h_be, h_wdata);
          end
        end
        if (waitc == delay) begin
          mem_ack = 1'b1;
          mem_rdata = mem_rd(mem_addr_o);
          if (mem_we_o) mem_wr(mem_addr_o, mem_be_o, mem_wdata_o);
          in_txn = 1'b0;
        end else begin
          waitc++;
        end
      end else if (!stall_o) begin
        done = 1'b1;
        exp_d = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 32'hDEAD_0000;
        n_checks++;
        if (data_o !== exp_d) begin
          n_fail++;
          $display("FAIL data_o got=%h want=%h (addr %h)", data_o, exp_d, a);
        end
      end
    end
    n_checks++;
    if (!done || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL access_complete done=%b pending_txns=%0d want done=1 pending=0",
               done, exp_q.size());
      exp_q.delete();
    end
    mem_ack = 1'b0;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    mem_write = 1'b0; mem_read = 1'b0; wdata = '0;
  endtask

  task automatic check_idle(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++;
      if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s req=%b stall=%b want req=0 stall=0", tag, mem_req_o, stall_o);
      end
    end
  endtask

  task automatic check_counts(input string tag, input int unsigned c, input int unsigned s,
                              input int unsigned ce, input int unsigned se);
    n_checks++;
    if (c !== ce || s !== se) begin
      n_fail++;
      $display("FAIL %s cycles=%0d stalls=%0d want cycles=%0d stalls=%0d", tag, c, s, ce, se);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_req_o, mem_we_o, stall_o, data_o, mem_be_o, mem_addr_o, mem_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs req=%b we=%b stall=%b data=%h be=%b addr=%h wdata=%h want all 0",
               mem_req_o, mem_we_o, stall_o, data_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle(2, "idle_after_reset");
  endtask

  task automatic test_aligned_store();
    int unsigned c, s;
    push_txn(32'h10, 1'b1, 4'b1111, 32'hDEADBEEF);
    exp_data_q.push_back(32'h0);
    run_access(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 2'b10, 1'b0, 0, c, s);
    check_counts("aligned_store_latency", c, s, 3, 2);
    go_idle();
    n_checks++;
    if (mem_rd(32'h10) !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL aligned_store_mem got=%h want=%h", mem_rd(32'h10), 32'hDEADBEEF);
    end
  endtask

  task automatic test_byte_load();
    int unsigned c, s;
    mem[32'h80] = 32'h12F45678;
    push_txn(32'h80, 1'b0, 4'b0010, 32'h0);
    exp_data_q.push_back(32'h00000056);
    run_access(32'h81, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0, 0, c, s);
    check_counts("byte_load_latency", c, s, 3, 2);
    push_txn(32'h80, 1'b0, 4'b0100, 32'h0);
    exp_data_q.push_back(32'hFFFFFFF4);
    run_access(32'h82, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0, 0, c, s);
    push_txn(32'h80, 1'b0, 4'b0100, 32'h0);
    exp_data_q.push_back(32'h000000F4);
    run_access(32'h82, 32'h0, 1'b0, 1'b1, 2'b00, 1'b1, 0, c, s);
    check_counts("back_to_back_latency", c, s, 3, 2);
    go_idle();
  endtask

  task automatic test_misaligned_store();
    int unsigned c, s;
    push_txn(32'h20, 1'b1, 4'b1000, 32'hDD000000);
    push_txn(32'h24, 1'b1, 4'b0111, 32'h00AABBCC);
    exp_data_q.push_back(32'h0);
    run_access(32'h23, 32'hAABBCCDD, 1'b1, 1'b0, 2'b10, 1'b0, 0, c, s);
    check_counts("split_store_latency", c, s, 5, 4);
    go_idle();
  endtask

  task automatic test_misaligned_half_load();
    int unsigned c, s;
    mem[32'h44] = 32'h11223344;
    mem[32'h48] = 32'h55667788;
    push_txn(32'h44, 1'b0, 4'b1000, 32'h0);
    push_txn(32'h48, 1'b0, 4'b0001, 32'h0);
    exp_data_q.push_back(32'hFFFF8811);
    run_access(32'h47, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, 0, c, s);
    check_counts("split_load_latency", c, s, 5, 4);
    go_idle();
  endtask

  task automatic test_delayed_ack();
    int unsigned c, s;
    push_txn(32'h30, 1'b1, 4'b1111, 32'h01020304);
    exp_data_q.push_back(32'h0);
    run_access(32'h30, 32'h01020304, 1'b1, 1'b0, 2'b10, 1'b0, 3, c, s);
    check_counts("delayed_ack_latency", c, s, 6, 5);
    go_idle();
    check_idle(3, "no_reissue");
  endtask

  task automatic test_boundaries();
    int unsigned c, s;
    push_txn(32'hFFFFFFFC, 1'b1, 4'b1100, 32'h33440000);
    push_txn(32'h00000000, 1'b1, 4'b0011, 32'h00001122);
    exp_data_q.push_back(32'h0);
    run_access(32'hFFFFFFFE, 32'h11223344, 1'b1, 1'b0, 2'b10, 1'b0, 1, c, s);
    check_counts("wrap_split_latency", c, s, 7, 6);
    push_txn(32'hFFFFFFFC, 1'b0, 4'b1100, 32'h0);
    exp_data_q.push_back(32'h00003344);
    run_access(32'hFFFFFFFE, 32'h0, 1'b0, 1'b1, 2'b01, 1'b1, 0, c, s);
    push_txn(32'h10, 1'b0, 4'b1111, 32'h0);
    exp_data_q.push_back(32'hDEADBEEF);
    run_access(32'h10, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0, 0, c, s);
    push_txn(32'h10, 1'b0, 4'b1100, 32'h0);
    exp_data_q.push_back(32'hFFFFDEAD);
    run_access(32'h12, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, 2, c, s);
    go_idle();
  endtask

  task automatic test_both_ops();
    int unsigned c, s;
    push_txn(32'h60, 1'b1, 4'b1111, 32'hCAFEF00D);
    exp_data_q.push_back(32'h0);
    run_access(32'h60, 32'hCAFEF00D, 1'b1, 1'b1, 2'b10, 1'b0, 0, c, s);
    go_idle();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    addr = 32'h50; mem_read = 1'b1; size = 2'b10; uns = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_req_before got=%b want=1", mem_req_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async req=%b stall=%b want req=0 stall=0", mem_req_o, stall_o);
    end
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle(4, "idle_after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_aligned_store();
    test_byte_load();
    test_misaligned_store();
    test_misaligned_half_load();
    test_delayed_ack();
    test_boundaries();
    test_both_ops();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_master.md
Name: data_mem_master

Overview:
- Initiator side of the MEM-stage data-memory interface: accepts the pipeline's byte-addressed load/store request (addr_i, data_i, MemWrite_i, MemRead_i) and drives a multi-cycle, word-organised memory over a req/ack handshake.
- Handles byte, halfword and word sizes, little-endian lane placement and misaligned accesses (split into two word transactions).
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 32, byte-address width; memory-side address is word-aligned with bits [1:0] forced to 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- addr_i  in  ADDR_W  byte address from pipeline
- data_i  in  32  store data, right-justified
- MemWrite_i  in  1  store request
- MemRead_i  in  1  load request
- size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- unsigned_i  in  1  load zero-extend (1) or sign-extend (0)
- data_o  out  32  load result
- stall_o  out  1  pipeline hold
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_W  word-aligned address
- mem_be_o  out  4  byte enables; bit k = byte lane k (bits [8k+7:8k])
- mem_wdata_o  out  32  write data, lane-placed
- mem_rdata_i  in  32  read data, valid when mem_ack_i=1
- mem_ack_i  in  1  transaction accepted/completed

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE; mem_req_o, mem_we_o, stall_o, data_o, mem_be_o, mem_addr_o, mem_wdata_o all 0. Reset mid-transaction drops mem_req_o immediately; the partial access is abandoned.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE: if MemRead_i|MemWrite_i, stall_o=1 combinationally in the same cycle. Latch addr, data, size, unsigned and op. Compute the split flag: split = (addr[1:0] + nbytes) > 4, with nbytes 1/2/4. Next state ACC0.
- Both MemWrite_i and MemRead_i high: the access is treated as a write; data_o stays 0.
- ACC0: mem_req_o=1, mem_addr_o={addr[ADDR_W-1:2],2'b00}, mem_be_o=(bytemask<<addr[1:0])[3:0].
  - mem_wdata_o = lower 32 bits of ({32'b0,data}<<8*addr[1:0]).
  - On mem_ack_i=1: capture mem_rdata_i into rlo; next state ACC1 if split, else DONE.
  - Without ack: hold all mem_* outputs stable.
- ACC1: mem_addr_o = word address + 4, wrapping modulo 2^ADDR_W. mem_be_o = bits [7:4] of the shifted mask. mem_wdata_o = upper 32 bits of the shifted data. On ack: capture rhi; next state DONE.
- stall_o=1 in ACC0 and ACC1.
- mem_req_o drops in the cycle after the final ack: it is 0 in DONE, and 0 for one cycle between ACC0 and ACC1.
- DONE: stall_o=0; one cycle only; next state IDLE.
  - For a read, data_o = ({rhi,rlo}>>8*addr[1:0]) masked to size, then sign- or zero-extended per unsigned_i.
  - Unused upper lanes of a non-split read are don't-care (rhi ignored).
- data_o is 0 in every state except DONE-after-read.
- Back-to-back: a new request is sampled in IDLE on the cycle after DONE. The DONE cycle never starts an access, so the completed instruction is not re-issued.
- Latency, mem_ack_i high on the first req cycle:
  - aligned: 3 cycles (IDLE, ACC0, DONE), stall_o high for 2 cycles.
  - split: 5 cycles (IDLE, ACC0, gap, ACC1, DONE).
  - Each extra cycle of missing ack adds one cycle.
- mem_we_o equals the latched op throughout ACC0/ACC1; 0 otherwise.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state encoding, byte-mask constants.
- Sub-module mem_lane_align, combinational:
  - inputs: offset, size, unsigned, store data, {rhi,rlo}
  - outputs: 8-bit byte mask, 64-bit shifted store data, extended load result.
- The FSM and handshake live in data_mem_master.

Test Plan:
- Aligned word store: addr 0x10, data 0xDEADBEEF, ack on first req cycle -> one txn with mem_addr 0x10, be 1111, wdata 0xDEADBEEF; stall_o high exactly 2 cycles.
- Signed byte load: memory word 0x80 holds 0x12F45678, addr 0x81, size 00, unsigned 0 -> data_o 0x00000056 in DONE. Repeat at addr 0x82 -> 0xFFFFFFF4; with unsigned 1 -> 0x000000F4.
- Misaligned word store: addr 0x23, data 0xAABBCCDD -> txn1 addr 0x20, be 1000, wdata 0xDD000000; txn2 addr 0x24, be 0111, wdata 0x00AABBCC.
- Misaligned half load: addr 0x47, word 0x44 = 0x11223344, word 0x48 = 0x55667788, signed -> two reads; data_o 0xFFFF8811.
- Ack delayed 3 cycles with stall_o held -> mem_addr_o, mem_wdata_o, mem_be_o stable throughout; stall_o high 5 cycles; no duplicate req after DONE.
- Reset asserted in ACC0 with mem_req_o high -> mem_req_o and stall_o go 0 without waiting for a clock edge. After release, with MemRead_i=MemWrite_i=0, the block stays idle.
